// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
// Consumed by imem_loader, its stream interface and the loader_csum accumulator.
package cpu_loader_pkg;

    localparam int unsigned WORD_W         = 32;
    localparam int unsigned ADDR_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        ERROR = 2'd2
    } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Valid/ready word stream feeding the loader: master = producer, slave = loader.
interface imem_loader_if;
    import cpu_loader_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              in_last;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );

endinterface

// File: rtl/imem_loader_csum.sv
// loader_csum: mod-2^32 running sum of accepted image words with a compare output.
// Only built when LOADER_CHECKSUM_EN is defined.
`ifdef LOADER_CHECKSUM_EN
module loader_csum
    import cpu_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              add,
    input  logic [WORD_W-1:0] add_data,
    input  logic [WORD_W-1:0] cmp_data,
    output logic              match
);

    logic [WORD_W-1:0] sum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else if (clr) begin
            sum_q <= '0;
        end else if (add) begin
            sum_q <= sum_q + add_data;
        end
    end

    // Compare against the sum of the words before the one on cmp_data.
    assign match = (sum_q == cmp_data);

endmodule
`endif

// File: rtl/imem_loader.sv
// Boot loader: streams words into instruction memory from address 0 and holds the CPU
// in reset until the image is complete. LOADER_CHECKSUM_EN makes the in_last word a checksum.
module imem_loader
    import cpu_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    imem_loader_if.slave        in_if,
    input  logic                reload,
    output logic                im_we,
    output logic [ADDR_W-1:0]   im_addr,
    output logic [WORD_W-1:0]   im_wdata,
    output logic                cpu_rst,
    output logic                done,
    output logic                err,
    output logic [ADDR_W:0]     word_count
);

    loader_state_t     state_q;
    loader_state_t     state_d;
    logic [ADDR_W-1:0] cnt_q;

    logic accept;
    logic at_end_addr;
    logic load_end;
    logic reload_go;
    logic is_csum_word;
    logic csum_bad;
    logic do_write;

    assign in_if.in_ready = (state_q == LOAD);
    assign accept         = in_if.in_valid && in_if.in_ready;
    assign at_end_addr    = (cnt_q == '1);
    assign load_end       = accept && (in_if.in_last || at_end_addr);
    assign reload_go      = reload && (state_q != LOAD);
    assign do_write       = accept && !is_csum_word;

`ifdef LOADER_CHECKSUM_EN
    logic csum_match;

    assign is_csum_word = in_if.in_last;
    assign csum_bad     = !csum_match;

    loader_csum u_csum (
        .clk      (clk),
        .rst      (rst),
        .clr      (reload_go),
        .add      (do_write),
        .add_data (in_if.in_data),
        .cmp_data (in_if.in_data),
        .match    (csum_match)
    );

    assign err = (state_q == ERROR);
`else
    assign is_csum_word = 1'b0;
    assign csum_bad     = 1'b0;
    assign err          = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD: begin
                if (load_end) begin
                    state_d = (is_csum_word && csum_bad) ? ERROR : RUN;
                end
            end
            RUN: begin
                if (reload) begin
                    state_d = LOAD;
                end
            end
            ERROR: begin
                if (reload) begin
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // Counter holds at the top address instead of wrapping; only reload rewinds it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            word_count <= '0;
        end else if (reload_go) begin
            cnt_q      <= '0;
            word_count <= '0;
        end else if (do_write) begin
            if (!at_end_addr) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (!word_count[ADDR_W]) begin
                word_count <= word_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_wdata <= '0;
        end else begin
            im_we <= do_write;
            if (do_write) begin
                im_addr  <= cnt_q;
                im_wdata <= in_if.in_data;
            end
        end
    end

    // Released one cycle after RUN is entered so the last write lands before the first fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_rst <= 1'b1;
        end else begin
            cpu_rst <= !((state_q == RUN) && !reload);
        end
    end

    assign done = (state_q == RUN);

endmodule

// File: tb/tb_imem_loader.sv
// Directed, table-driven bench for imem_loader (default depth plus an ADDR_W=4 instance).
module tb_imem_loader;
    import cpu_loader_pkg::*;

`ifdef LOADER_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    typedef struct {
        logic        valid;
        logic [31:0] data;
        logic        last;
        logic        rl;
        logic        e_ready;
        logic        e_we;
        logic [7:0]  e_addr;
        logic [31:0] e_wdata;
        logic [8:0]  e_wc;
        logic        e_done;
        logic        e_cpu_rst;
        logic        e_err;
    } vec_t;

    logic clk_tb = 1'b0;
    logic rst    = 1'b1;
    logic reload = 1'b0;
    logic reload4 = 1'b0;

    logic        im_we,  im_we4;
    logic [7:0]  im_addr;
    logic [3:0]  im_addr4;
    logic [31:0] im_wdata, im_wdata4;
    logic        cpu_rst, cpu_rst4, done, done4, err, err4;
    logic [8:0]  word_count;
    logic [4:0]  word_count4;

    int tests  = 0;
    int failed = 0;
    vec_t tbl[$];

    imem_loader_if bus8();
    imem_loader_if bus4();

    imem_loader #(.ADDR_W(8)) dut (
        .clk        (clk_tb),
        .rst        (rst),
        .in_if      (bus8),
        .reload     (reload),
        .im_we      (im_we),
        .im_addr    (im_addr),
        .im_wdata   (im_wdata),
        .cpu_rst    (cpu_rst),
        .done       (done),
        .err        (err),
        .word_count (word_count)
    );

    imem_loader #(.ADDR_W(4)) dut4 (
        .clk        (clk_tb),
        .rst        (rst),
        .in_if      (bus4),
        .reload     (reload4),
        .im_we      (im_we4),
        .im_addr    (im_addr4),
        .im_wdata   (im_wdata4),
        .cpu_rst    (cpu_rst4),
        .done       (done4),
        .err        (err4),
        .word_count (word_count4)
    );

    always #5 clk_tb = ~clk_tb;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] word_of(input int i);
        return 32'hC0DE_0000 + i * 32'h0000_0101;
    endfunction

    function automatic vec_t mk(input bit valid, input logic [31:0] data, input bit last,
                                input bit rl, input bit rdy, input bit we, input int addr,
                                input logic [31:0] wd, input int wc, input bit dn,
                                input bit cr, input bit er);
        vec_t v;
        v.valid = valid;  v.data = data;  v.last = last;  v.rl = rl;
        v.e_ready = rdy;  v.e_we = we;    v.e_addr = addr[7:0];
        v.e_wdata = wd;   v.e_wc = wc[8:0];
        v.e_done = dn;    v.e_cpu_rst = cr;  v.e_err = er;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int n);
        bus8.in_valid = v.valid;
        bus8.in_data  = v.data;
        bus8.in_last  = v.last;
        reload        = v.rl;
        @(posedge clk_tb);
        #1;
        check($sformatf("v%0d.in_ready", n), bus8.in_ready, v.e_ready);
        check($sformatf("v%0d.im_we", n), im_we, v.e_we);
        if (v.e_we) begin
            check($sformatf("v%0d.im_addr", n), im_addr, v.e_addr);
            check($sformatf("v%0d.im_wdata", n), im_wdata, v.e_wdata);
        end
        check($sformatf("v%0d.word_count", n), word_count, v.e_wc);
        check($sformatf("v%0d.done", n), done, v.e_done);
        check($sformatf("v%0d.cpu_rst", n), cpu_rst, v.e_cpu_rst);
        check($sformatf("v%0d.err", n), err, v.e_err);
    endtask

    task automatic run_table();
        foreach (tbl[i]) apply(tbl[i], i);
        tbl.delete();
        bus8.in_valid = 1'b0;
        bus8.in_last  = 1'b0;
        reload        = 1'b0;
    endtask

    // n-word image, in_valid held high, followed by two RUN cycles offering a stray word.
    task automatic add_load(input int n);
        logic [31:0] sum;
        logic [31:0] d;
        bit          last, wr;
        int          wc, nw;
        sum = '0;
        for (int i = 0; i < n; i++) begin
            last = (i == n - 1);
            d    = (last && CSUM) ? sum : word_of(i);
            wr   = !(last && CSUM);
            wc   = wr ? i + 1 : i;
            tbl.push_back(mk(1, d, last, 0, !last, wr, i, d, wc, last, 1, 0));
            sum  = sum + word_of(i);
        end
        nw = CSUM ? n - 1 : n;
        tbl.push_back(mk(1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, nw, 1, 0, 0));
        tbl.push_back(mk(1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, nw, 1, 0, 0));
    endtask

    task automatic throttled();
        int          idx, cyc;
        bit          v, last, wr;
        logic [31:0] d, sum;
        idx = 0; cyc = 0; sum = '0;
        while (idx < 24 && cyc < 400) begin
            v    = 1'($urandom_range(0, 1));
            last = (idx == 23);
            d    = (last && CSUM) ? sum : word_of(idx);
            bus8.in_valid = v;
            bus8.in_data  = d;
            bus8.in_last  = last;
            check("thr.in_ready", bus8.in_ready, 1);
            @(posedge clk_tb);
            #1;
            wr = v && !(last && CSUM);
            check("thr.im_we", im_we, wr);
            if (wr) begin
                check("thr.im_addr", im_addr, idx);
                check("thr.im_wdata", im_wdata, d);
            end
            if (v) begin
                sum = sum + word_of(idx);
                idx++;
            end
            cyc++;
        end
        check("thr.accepted", idx, 24);
        bus8.in_valid = 1'b0;
        bus8.in_last  = 1'b0;
        @(posedge clk_tb);
        #1;
        check("thr.word_count", word_count, CSUM ? 23 : 24);
        check("thr.done", done, 1);
        check("thr.cpu_rst", cpu_rst, 0);
        check("thr.im_we_idle", im_we, 0);
    endtask

    task automatic depth_boundary();
        for (int i = 0; i < 20; i++) begin
            bus4.in_valid = 1'b1;
            bus4.in_data  = word_of(i);
            bus4.in_last  = 1'b0;
            @(posedge clk_tb);
            #1;
            check($sformatf("d4[%0d].im_we", i), im_we4, i < 16);
            if (i < 16) begin
                check($sformatf("d4[%0d].im_addr", i), im_addr4, i);
                check($sformatf("d4[%0d].im_wdata", i), im_wdata4, word_of(i));
            end
            check($sformatf("d4[%0d].word_count", i), word_count4, (i < 16) ? i + 1 : 16);
            check($sformatf("d4[%0d].in_ready", i), bus4.in_ready, i < 15);
            check($sformatf("d4[%0d].done", i), done4, i >= 15);
            check($sformatf("d4[%0d].cpu_rst", i), cpu_rst4, i < 16);
        end
        bus4.in_valid = 1'b0;
    endtask

    initial begin
        bus8.in_valid = 1'b0; bus8.in_data = '0; bus8.in_last = 1'b0;
        bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.in_last = 1'b0;

        // Power-on reset values.
        repeat (2) @(posedge clk_tb);
        #1;
        check("por.im_we", im_we, 0);
        check("por.im_addr", im_addr, 0);
        check("por.cpu_rst", cpu_rst, 1);
        check("por.done", done, 0);
        check("por.word_count", word_count, 0);
        @(negedge clk_tb);
        rst = 1'b0;

        // Partial load, then asynchronous reset asserted mid-cycle.
        for (int i = 0; i < 5; i++) begin
            bus8.in_valid = 1'b1;
            bus8.in_data  = word_of(i);
            @(posedge clk_tb);
            #1;
        end
        check("pre.im_addr", im_addr, 4);
        #2;
        rst = 1'b1;
        #1;
        check("arst.im_we", im_we, 0);
        check("arst.im_addr", im_addr, 0);
        check("arst.im_wdata", im_wdata, 0);
        check("arst.word_count", word_count, 0);
        check("arst.cpu_rst", cpu_rst, 1);
        check("arst.done", done, 0);
        check("arst.err", err, 0);
        bus8.in_valid = 1'b0;
        @(negedge clk_tb);
        rst = 1'b0;
        #1;
        check("arst.in_ready", bus8.in_ready, 1);

        // Nominal 24-word load, reload from RUN, then a 4-word load.
        add_load(24);
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0));
        add_load(4);
        run_table();

        // Throttled producer after another reload.
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0));
        run_table();
        throttled();

`ifdef LOADER_CHECKSUM_EN
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 1, 0, 1, 1, 0, 1, 0));
        tbl.push_back(mk(1, 2, 0, 0, 1, 1, 1, 2, 2, 0, 1, 0));
        tbl.push_back(mk(1, 3, 0, 0, 1, 1, 2, 3, 3, 0, 1, 0));
        tbl.push_back(mk(1, 6, 1, 0, 0, 0, 0, 0, 3, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 1, 0, 1, 1, 0, 1, 0));
        tbl.push_back(mk(1, 2, 0, 0, 1, 1, 1, 2, 2, 0, 1, 0));
        tbl.push_back(mk(1, 3, 0, 0, 1, 1, 2, 3, 3, 0, 1, 0));
        tbl.push_back(mk(1, 7, 1, 0, 0, 0, 0, 0, 3, 0, 1, 1));
        tbl.push_back(mk(1, 9, 0, 0, 0, 0, 0, 0, 3, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0));
        // Checksum-only image of value 0: nothing written, still valid.
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        run_table();
`endif

        depth_boundary();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader between the host/test harness and the single-cycle CPU's instruction memory. Accepts 32-bit instruction words over a valid/ready stream, writes them to consecutive word addresses starting at 0, and holds the CPU in reset until the load completes. It then releases the CPU so that PC = 0 fetches the freshly written program.

## Interface
Parameters:
- ADDR_W, default 8: instruction-memory word-address width; depth = 2^ADDR_W words.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  producer has a word.
- in_ready  out  1  loader accepts a word this cycle.
- in_data  in  32  instruction word.
- in_last  in  1  marks the final word of the image.
- reload  in  1  single-cycle pulse that restarts loading from RUN or ERROR.
- im_we  out  1  instruction-memory write enable.
- im_addr  out  ADDR_W  instruction-memory word address.
- im_wdata  out  32  instruction-memory write data.
- cpu_rst  out  1  reset to the CPU, active-high.
- done  out  1  high in RUN.
- err  out  1  high in ERROR.
- word_count  out  ADDR_W+1  number of words written in the current load.

## Operation
- States: LOAD, RUN, ERROR.
- Reset values:
  - state = LOAD; address counter = 0; word_count = 0.
  - im_we = 0; im_addr = 0; im_wdata = 0.
  - cpu_rst = 1; done = 0; err = 0.
- LOAD:
  - in_ready = 1.
  - An accept (in_valid && in_ready) registers im_we = 1, im_addr = counter, im_wdata = in_data, then increments counter and word_count.
- Load end: the accept carries in_last = 1, or the accept is at counter = 2^ADDR_W − 1. The second case also completes the load, and no further words are accepted. Next state is RUN.
- RUN:
  - in_ready = 0; done = 1; cpu_rst = 0.
  - Words offered while in RUN are not accepted; in_valid is ignored.
- ERROR (checksum builds only):
  - in_ready = 0; err = 1; cpu_rst = 1.
- reload:
  - In RUN or ERROR: next state LOAD; counter and word_count clear; done and err drop; cpu_rst = 1.
  - In LOAD: ignored.
- Arithmetic: counter wraps only on reload, never mid-load. word_count saturates at 2^ADDR_W.
- Async reset mid-load: aborts immediately and returns all reset values. Memory contents are undefined; the image must be reloaded.

## Timing
- Write latency: an accept at edge T produces im_we = 1 during cycle T+1, one cycle wide. Back-to-back accepts give continuous im_we.
- Release: final accept at T gives state RUN at T+1 and cpu_rst = 0 from T+2. The last write is committed before the CPU's first fetch.
- Re-entry: reload sampled at T gives cpu_rst = 1 and in_ready = 1 from T+1.
- in_ready is a registered state decode and does not depend on in_valid.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - The in_last word is a checksum. It is not written to memory and is not counted.
  - The loader compares it against the mod-2^32 sum of all previously accepted words.
  - Match: RUN, with the timing above.
  - Mismatch: ERROR at T+1; cpu_rst stays 1.
  - A load ended by full depth (without in_last) goes to RUN without a check.
  - An image of only the checksum word writes nothing; it is valid when that word is 0.
- LOADER_CHECKSUM_EN undefined:
  - The in_last word is written like any other.
  - ERROR is unreachable; err is tied to 0.

## Structure
- Package cpu_loader_pkg:
  - loader_state_t enum (LOAD, RUN, ERROR).
  - Word-width constant WORD_W = 32.
  - Default ADDR_W.
- Sub-module loader_csum: 32-bit accumulator with clear, add-on-accept, and compare output. Instantiated only under LOADER_CHECKSUM_EN.

## Test plan
- Reset check: assert rst mid-cycle → all outputs at reset values immediately; in_ready = 1 after release.
- Nominal load (checksum off): stream 24 words, in_valid held high, in_last on the 24th → 24 consecutive im_we pulses at addresses 0..23 with matching data, word_count = 24, done = 1, cpu_rst = 0 exactly two cycles after the last accept.
- Throttled producer: the same 24 words with in_valid toggled randomly → identical memory contents and word_count; im_we is asserted only for the cycle after each accept.
- Depth boundary (ADDR_W = 4): offer 20 words with no in_last → 16 writes at 0..15, RUN entered, words 17–20 never accepted, word_count = 16.
- Checksum (LOADER_CHECKSUM_EN defined): words 1, 2, 3 then checksum 6 → 3 writes, RUN; repeat with checksum 7 → ERROR, err = 1, cpu_rst stays 1.
- Reload: from RUN, pulse reload, then load 4 words → cpu_rst = 1 one cycle after the pulse, writes restart at address 0, RUN re-entered.
